// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: assembles little-endian 32-bit words from a
// byte stream, writes them sequentially from word 0, and holds the core in reset
// until the image has been written.
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(DEPTH - 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0] word_cnt_q, word_cnt_d;
    logic [31:0]         word_buf_q, word_buf_d;
    logic                last_seen_q, last_seen_d;
    logic                err_q, err_d;

    // Next-state logic: byte assembly in LOAD, one-cycle write, terminal DONE.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        word_buf_d  = word_buf_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        case (state_q)
            ST_LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone marks a transfer
                if (in_valid) begin
                    word_buf_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3 || in_last) begin
                        state_d = ST_WRITE;
                    end
                    if (in_last) begin
                        last_seen_d = 1'b1;
                        // Image ended mid-word: the word is still written, zero-padded
                        if (byte_idx_q != 2'd3) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                word_buf_d = '0;
                byte_idx_d = '0;
                if (last_seen_q) begin
                    state_d = ST_DONE;
                end else if (word_cnt_q == LAST_WORD) begin
                    // Memory full but the stream has not ended
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (reload) begin
                    state_d     = ST_LOAD;
                    word_cnt_d  = '0;
                    word_buf_d  = '0;
                    byte_idx_d  = '0;
                    last_seen_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State registers with asynchronous reset back to an empty LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            byte_idx_q  <= '0;
            word_cnt_q  <= '0;
            word_buf_q  <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            word_buf_q  <= word_buf_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        in_ready   = (state_q == ST_LOAD);
        imem_we    = (state_q == ST_WRITE);
        imem_addr  = word_cnt_q[ADDR_WIDTH-1:0];
        imem_wdata = word_buf_q;
        cpu_hold   = (state_q != ST_DONE);
        done       = (state_q == ST_DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader with a small (4-word) memory so that
// overflow is reachable; expected writes come from a byte-list model.
module tb_instr_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    int            checks  = 0;
    int            errors  = 0;
    int            inv_bad = 0;
    logic [7:0]    img[$];
    logic [31:0]   exp_words[$];
    logic          exp_err;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic          done_prev = 1'b0;
    logic          we_prev   = 1'b0;
    bit            timeout;
    longint        elapsed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Records memory writes and checks handshake/hold invariants every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_ready !== (!imem_we && !done)) inv_bad++;
            if (cpu_hold !== !done) inv_bad++;
            if (done && !done_prev && !we_prev) inv_bad++;
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
        end
        done_prev = done;
        we_prev   = imem_we;
    end

    // Model: words are consecutive 4-byte groups, zero-padded, truncated at DEPTH.
    task automatic build_expect(input bit lastf);
        int n, nw_raw, nw;
        logic [31:0] w;
        n      = img.size();
        nw_raw = lastf ? (n + 3) / 4 : DEPTH + 1;
        nw     = (nw_raw > DEPTH) ? DEPTH : nw_raw;
        exp_err = (nw_raw > DEPTH) || (n % 4 != 0);
        exp_words.delete();
        for (int k = 0; k < nw; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * k + b < n) w = w | (32'(img[4 * k + b]) << (8 * b));
            end
            exp_words.push_back(w);
        end
    endtask

    task automatic send_image(input bit lastf, input int gap_pct);
        int t;
        timeout = 0;
        for (int i = 0; i < img.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = img[i];
            in_last  = lastf && (i == img.size() - 1);
            t = 0;
            while (!in_ready && !done && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                if (!done) timeout = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_case(input string tag, input bit lastf, input int gap_pct);
        longint t0;
        build_expect(lastf);
        wr_addr.delete();
        wr_data.delete();
        t0 = $time;
        send_image(lastf, gap_pct);
        wait_done();
        elapsed = $time - t0;
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".hold"}, 32'(cpu_hold), 32'd0);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".nwrites"}, 32'(wr_data.size()), 32'(exp_words.size()));
        for (int i = 0; i < wr_data.size() && i < exp_words.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("%s.data%0d", tag, i), wr_data[i], exp_words[i]);
        end
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".hold"}, 32'(cpu_hold), 32'd1);
        check({tag, ".err"}, 32'(err), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        check({tag, ".we"}, 32'(imem_we), 32'd0);
        check({tag, ".addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".wdata"}, imem_wdata, 32'd0);
        check({tag, ".hold"}, 32'(cpu_hold), 32'd1);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
    endtask

    initial begin
        bit lastf;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        #1;
        reset_checks("por");
        @(negedge clk);
        reset = 1'b0;

        // Happy path, in_valid held: two words, 5 cycles per word
        img = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        run_case("happy", 1'b1, 0);
        check("happy.w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'h00500513);
        check("happy.w1", (wr_data.size() > 1) ? wr_data[1] : 32'hx, 32'h00A00593);
        check("happy.cycles", 32'(elapsed), 32'd100);

        // Same image with random valid gaps
        do_reload("rl1");
        run_case("gaps", 1'b1, 40);

        // Partial final word
        do_reload("rl2");
        img = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h01};
        run_case("partial", 1'b1, 0);
        check("partial.w1", (wr_data.size() > 1) ? wr_data[1] : 32'hx, 32'h000001EF);

        // Overflow: 20 bytes, no last, into a 4-word memory
        do_reload("rl3");
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
        run_case("ovf", 1'b0, 20);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("ovf.stall%0d", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("ovf.nwrites_after", 32'(wr_data.size()), 32'(DEPTH));

        // Reset mid-load, then a fresh one-word image
        do_reload("rl4");
        img.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
        wr_data.delete();
        wr_addr.delete();
        send_image(1'b0, 0);
        check("midrst.prewrites", 32'(wr_data.size()), 32'd1);
        reset = 1'b1;
        #1;
        reset_checks("midrst");
        @(negedge clk);
        reset = 1'b0;
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_case("restart", 1'b1, 0);
        check("restart.w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'hDDCCBBAA);

        // Reload after a completed load clears err from the partial case
        img = '{8'h6F, 8'h00};
        do_reload("rl5");
        run_case("errload", 1'b1, 0);
        do_reload("rl6");
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_case("reload", 1'b1, 10);
        check("reload.w0", (wr_data.size() > 0) ? wr_data[0] : 32'hx, 32'h04030201);

        // Random images, with and without in_last
        for (int k = 0; k < 10; k++) begin
            do_reload($sformatf("rrl%0d", k));
            lastf = 1'($urandom_range(1));
            n = lastf ? int'($urandom_range(20, 1)) : int'($urandom_range(20, 16));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_case($sformatf("rand%0d", k), lastf, int'($urandom_range(50)));
        end

        check("invariants", 32'(inv_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially into instruction memory from word address 0 and holds the core in reset until the image is complete. It produces the instruction words that the core's decode path later consumes.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies final byte of image; sampled only with in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  in DONE, restarts a fresh load; ignored in other states.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word being written.
- cpu_hold  output  1  high keeps the core in reset; low releases it.
- done  output  1  load complete.
- err  output  1  sticky; image malformed (partial final word or overflow).

## Operation
- Registers: state, byte_idx[1:0], word_cnt[ADDR_WIDTH:0], buf[31:0], last_seen, err.
- A byte transfers when in_valid & in_ready are both high on a rising edge.
- Assembly is little-endian. The accepted byte with byte_idx=n goes to buf[8n+7:8n]. byte_idx increments mod 4.
- States:
  - LOAD: in_ready=1. On a transfer, store the byte. If byte_idx==3 or in_last=1, go to WRITE. If in_last=1, set last_seen. If in_last=1 and byte_idx!=3, set err. Otherwise stay in LOAD.
  - WRITE: in_ready=0. imem_we=1, imem_addr=word_cnt[ADDR_WIDTH-1:0], imem_wdata=buf. Bytes not filled are 0. On exit, word_cnt++, buf<=0, byte_idx<=0.
    - If last_seen, go to DONE.
    - Otherwise, if word_cnt==DEPTH-1, set err and go to DONE (overflow; rest of stream is not accepted).
    - Otherwise go to LOAD.
  - DONE: in_ready=0, imem_we=0, cpu_hold=0, done=1.
    - If reload=1, go to LOAD. Clear word_cnt, buf, byte_idx, last_seen and err.
    - Otherwise stay in DONE indefinitely.
- cpu_hold=1 and done=0 in every state except DONE.
- imem_addr and imem_wdata are don't-care when imem_we=0; they are driven from the registers in every state.
- in_valid without in_ready (in WRITE or DONE) is ignored. Upstream must hold the byte until it is accepted.
- A zero-length image is not expressible; every image has at least one byte.

## Timing
- Reset (asynchronous assert) sets:
  - state=LOAD, all counters, buf, last_seen and err = 0.
  - Outputs: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0.
- Reset released mid-load: the load restarts from address 0. Previously written words are overwritten by the new stream.
- Write latency: the 4th byte (or last byte) accepted at edge k produces imem_we=1 during cycle k..k+1. Memory captures the word at edge k+1.
- Throughput: 4 bytes per 5 cycles with in_valid held high. in_ready drops for exactly one cycle per word.
- Done latency: done=1 and cpu_hold=0 in the cycle after the final WRITE cycle.
- reload at edge j returns to LOAD. in_ready=1, cpu_hold=1 and done=0 from cycle j onward.
- All outputs are combinational decodes of registered state. There is no path from in_valid or in_last to any output.

## Test plan
- Happy path: stream 13 05 50 00 93 05 A0 00 with in_last on the 8th byte -> two writes: addr0=0x00500513, addr1=0x00A00593. Then done=1, cpu_hold=0, err=0.
- Backpressure/gaps: same 8 bytes with random in_valid gaps -> identical writes. in_ready=0 exactly in each WRITE cycle. No bytes lost or duplicated.
- Partial word: bytes 6F 00 00 00 EF 01 with in_last on EF 01 -> addr0=0x0000006F, addr1=0x000001EF, done=1, err=1.
- Overflow with ADDR_WIDTH=2: 20 bytes, no in_last -> 4 writes at addr 0..3. Then done=1, err=1, in_ready stays 0.
- Reset mid-load: assert reset after 6 bytes, then stream 4 bytes AA BB CC DD with last -> single write addr0=0xDDCCBBAA. done=1.
- Reload: after a completed load, pulse reload, then stream 4 bytes 01 02 03 04 with last -> cpu_hold=1 and done=0 during the reload. Write addr0=0x04030201, err cleared, done=1.
